// File: rtl/handshake_const_check_pkg.sv
// Shared types and helpers for the handshake buffer family: buffer
// occupancy state and a saturating counter increment.
package handshake_const_check_pkg;

  typedef enum logic [0:0] {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } buf_state_e;

  // Counters up to 32 bits wide share this helper; max_val is the all-ones
  // value of the caller's counter width.
  function automatic logic [31:0] sat_inc(input logic [31:0] val,
                                          input logic [31:0] max_val);
    logic [31:0] res;
    if (val >= max_val) begin
      res = val;
    end else begin
      res = val + 32'd1;
    end
    return res;
  endfunction

endpackage

// File: rtl/handshake_oehb_1b.sv
// One-entry opaque buffer carrying a 1-bit token. ins_ready depends only on
// the buffer state and outs_ready, never on ins_valid.
module handshake_oehb_1b
  import handshake_const_check_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic ins,
  input  logic ins_valid,
  output logic ins_ready,
  output logic outs,
  output logic outs_valid,
  input  logic outs_ready
);

  buf_state_e state_r;
  buf_state_e state_next_s;
  logic       ins_ready_s;
  logic       load_s;
  logic       outs_r;

  // Buffer occupancy register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_EMPTY;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state and ready logic
  always_comb begin
    state_next_s = state_r;
    ins_ready_s  = 1'b1;
    case (state_r)
      ST_EMPTY: begin
        ins_ready_s = 1'b1;
        if (ins_valid) begin
          state_next_s = ST_FULL;
        end else begin
          state_next_s = ST_EMPTY;
        end
      end
      ST_FULL: begin
        ins_ready_s = outs_ready;
        if (outs_ready && !ins_valid) begin
          state_next_s = ST_EMPTY;
        end else begin
          state_next_s = ST_FULL;
        end
      end
      default: begin
        ins_ready_s  = 1'b1;
        state_next_s = ST_EMPTY;
      end
    endcase
  end

  assign load_s = ins_valid & ins_ready_s;

  // Token register; holds while stalled so outs stays stable under backpressure
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      outs_r <= 1'b0;
    end else if (load_s) begin
      outs_r <= ins;
    end
  end

  assign ins_ready  = ins_ready_s;
  assign outs       = outs_r;
  assign outs_valid = (state_r == ST_FULL);

endmodule

// File: rtl/handshake_const_check.sv
// Consumer-side constant checker: turns each accepted token into a match flag
// and keeps saturating match/mismatch statistics plus the first bad value.
module handshake_const_check
  import handshake_const_check_pkg::*;
#(
  parameter int          DATA_WIDTH  = 32,
  parameter logic [31:0] CONST_VALUE = 32'h001A48D7,
  parameter int          CNT_WIDTH   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] ins,
  input  logic                  ins_valid,
  output logic                  ins_ready,
  output logic                  outs,
  output logic                  outs_valid,
  input  logic                  outs_ready,
  input  logic                  clr_stats,
  output logic [CNT_WIDTH-1:0]  match_count,
  output logic [CNT_WIDTH-1:0]  mismatch_count,
  output logic                  mismatch_seen,
  output logic [DATA_WIDTH-1:0] first_bad
);

  localparam logic [DATA_WIDTH-1:0] CONST_D = DATA_WIDTH'(CONST_VALUE);
  localparam logic [31:0] CNT_MAX = 32'((64'd1 << CNT_WIDTH) - 64'd1);

  logic                  match_s;
  logic                  ins_ready_s;
  logic                  accept_s;
  logic [CNT_WIDTH-1:0]  match_count_r;
  logic [CNT_WIDTH-1:0]  mismatch_count_r;
  logic                  mismatch_seen_r;
  logic [DATA_WIDTH-1:0] first_bad_r;

  assign match_s  = (ins == CONST_D);
  assign accept_s = ins_valid & ins_ready_s;

  handshake_oehb_1b u_buf (
    .clk        (clk),
    .rst        (rst),
    .ins        (match_s),
    .ins_valid  (ins_valid),
    .ins_ready  (ins_ready_s),
    .outs       (outs),
    .outs_valid (outs_valid),
    .outs_ready (outs_ready)
  );

  // Statistics; clear wins over a same-cycle accept, which then goes uncounted
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      match_count_r    <= '0;
      mismatch_count_r <= '0;
      mismatch_seen_r  <= 1'b0;
      first_bad_r      <= '0;
    end else if (clr_stats) begin
      match_count_r    <= '0;
      mismatch_count_r <= '0;
      mismatch_seen_r  <= 1'b0;
      first_bad_r      <= '0;
    end else if (accept_s) begin
      if (match_s) begin
        match_count_r <= CNT_WIDTH'(sat_inc(32'(match_count_r), CNT_MAX));
      end else begin
        mismatch_count_r <= CNT_WIDTH'(sat_inc(32'(mismatch_count_r), CNT_MAX));
        if (!mismatch_seen_r) begin
          first_bad_r     <= ins;
          mismatch_seen_r <= 1'b1;
        end
      end
    end
  end

  assign ins_ready      = ins_ready_s;
  assign match_count    = match_count_r;
  assign mismatch_count = mismatch_count_r;
  assign mismatch_seen  = mismatch_seen_r;
  assign first_bad      = first_bad_r;

endmodule

// File: doc/handshake_const_check.md
Name: handshake_const_check

Overview:
- Consumer-side counterpart of the constant-producer handshake block. It sits on a data channel that carries constant tokens and checks each token against the expected constant.
- Every accepted data token is converted into a 1-bit match token on a dataless-style control channel, through a one-entry opaque output buffer with 1-cycle latency.
- It keeps saturating match/mismatch statistics and captures the first mismatching value for debug and observability.

Parameters:
- DATA_WIDTH, 32: width of the `ins` data channel.
- CONST_VALUE, 32'h001A48D7: expected token value, truncated/zero-extended to DATA_WIDTH.
- CNT_WIDTH, 16: width of each statistics counter.

Ports:
- clk  in  1  single clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset (asserted at 0)
- ins  in  DATA_WIDTH  data token to check
- ins_valid  in  1  data token present
- ins_ready  out  1  block can accept token this cycle
- outs  out  1  match flag of buffered token (1 = ins equalled CONST_VALUE)
- outs_valid  out  1  buffered token present
- outs_ready  in  1  downstream accepts token
- clr_stats  in  1  synchronous clear of counters, sticky flag and capture register
- match_count  out  CNT_WIDTH  saturating count of matching tokens accepted
- mismatch_count  out  CNT_WIDTH  saturating count of mismatching tokens accepted
- mismatch_seen  out  1  sticky: at least one mismatch since reset/clear
- first_bad  out  DATA_WIDTH  value of first mismatching token since reset/clear

Behaviour:
- Reset (rst=0, async): buffer EMPTY, outs_valid=0, outs=0, both counters=0, mismatch_seen=0, first_bad=0. ins_ready is combinational, so it reads 1 during reset.
- Transfers:
  - Input transfer = ins_valid & ins_ready on a rising edge.
  - Output transfer = outs_valid & outs_ready.
- Buffer FSM, two states:
  - EMPTY: outs_valid=0, ins_ready=1. An input transfer loads outs <= (ins==CONST_VALUE) and moves to FULL.
  - FULL: outs_valid=1, ins_ready=outs_ready, with no combinational path from ins_valid to ins_ready.
    - Output transfer with no input transfer -> EMPTY.
    - Output and input transfer in the same cycle -> stay FULL, load new flag (full throughput, 1 token/cycle).
    - No output transfer -> hold outs stable. Required for protocol compliance: outs and outs_valid must not change while outs_valid=1 & outs_ready=0.
- Latency: token accepted at edge N is visible on outs/outs_valid after edge N; earliest downstream transfer is in cycle N+1.
- Comparison covers the full DATA_WIDTH bits. ins is don't-care when ins_valid=0 and must not affect any state.
- Statistics (updated on input transfer only):
  - Match: match_count += 1, saturating at all-ones.
  - Mismatch: mismatch_count += 1, saturating at all-ones.
  - Mismatch while mismatch_seen=0: first_bad <= ins and mismatch_seen <= 1. Later mismatches never overwrite first_bad.
- clr_stats=1 at an edge: counters, mismatch_seen and first_bad go to 0. This has priority over a same-cycle increment, so the token is not counted. The buffer/handshake path is unaffected and the token still flows to outs.
- Reset mid-transfer: a token in the buffer is dropped. No partial state survives and the block comes up in EMPTY.
- Saturation: at all-ones the counter holds. There is no wrap and no overflow flag.

Decomposition:
- Shared package: a buffer state enum (ST_EMPTY, ST_FULL) and a saturating-increment helper function, both reused by other handshake buffers.
- One natural sub-module, handshake_oehb_1b: the 1-bit one-entry opaque buffer (FSM + outs register). The top level adds the comparator, counters, sticky flag and capture register.

Test Plan:
1. Reset with rst=0 while ins_valid=1 -> outs_valid=0, ins_ready=1, counters=0, mismatch_seen=0. Release, then drive ins=32'h001A48D7, outs_ready=1 -> outs_valid=1, outs=1 next cycle; match_count=1.
2. Stream 8 back-to-back tokens (alternating 32'h001A48D7 / 32'h0) with outs_ready=1 -> one output per cycle, outs toggling 1/0, match_count=4, mismatch_count=4, first_bad=0, mismatch_seen=1.
3. Backpressure: outs_ready=0 with a FULL buffer holding outs=1, then offer ins=32'hDEADBEEF for 5 cycles -> ins_ready=0, outs stays 1, counters unchanged. Raise outs_ready -> 0xDEADBEEF accepted that cycle, outs=0 next.
4. Mismatch sequence 0x5, 0x7 -> first_bad=0x5 retained, mismatch_count=2. clr_stats pulsed together with an accepted 0x9 -> counters=0, first_bad=0, mismatch_seen=0, outs=0 still delivered.
5. CNT_WIDTH=4: 20 matching tokens -> match_count holds at 4'hF, no wrap.
6. Async rst asserted mid-cycle while FULL and outs_ready=0 -> outs_valid drops immediately (before the next edge); after release, block is EMPTY and accepts a new token.
